// File: rtl/bg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bg_pkg
// Brief    : Shared constants, FSM state and platform entry type for the
//            background painter and its colour lookup.
// Revision : 1.0
// ============================================================================
package bg_pkg;

    // Platform entry field widths; must equal the painter's X_W / Y_W
    localparam int PLAT_X_W = 9;
    localparam int PLAT_Y_W = 9;

    localparam logic [2:0] PLATFORM_COLOUR = 3'b111;
    localparam logic [2:0] GRASS_COLOUR    = 3'b010;
    localparam logic [2:0] TREE_COLOUR     = 3'b111;
    localparam logic [2:0] GRAVE_COLOUR    = 3'b111;

    localparam int GRASS_Y0 = 236;
    localparam int GRASS_Y1 = 250;
    localparam int TREE_X0  = 15;
    localparam int TREE_X1  = 45;
    localparam int GRAVE_X  = 245;
    localparam int GRAVE_W  = 6;
    localparam int GRAVE_Y  = 169;
    localparam int GRAVE_H  = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic                en;
        logic [PLAT_X_W-1:0] x_start;
        logic [PLAT_X_W-1:0] x_end;
        logic [PLAT_Y_W-1:0] y;
    } plat_t;

endpackage
`default_nettype wire

// File: rtl/bg_colour_lookup.sv
`default_nettype none
// ============================================================================
// Module   : bg_colour_lookup
// Brief    : Combinational (x, y, platform table) -> background colour.
// Revision : 1.0
// ============================================================================
module bg_colour_lookup
    import bg_pkg::*;
#(
    parameter int H_RES    = 320,
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int NUM_PLAT = 8,
    parameter int COLOUR_W = 3
) (
    input  logic [X_W-1:0]      x,
    input  logic [Y_W-1:0]      y,
    input  plat_t               plat_tbl [NUM_PLAT],
    output logic [COLOUR_W-1:0] colour
);

    localparam logic [X_W-1:0] C_X_MAX    = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] C_GRASS_Y0 = Y_W'(GRASS_Y0);
    localparam logic [Y_W-1:0] C_GRASS_Y1 = Y_W'(GRASS_Y1);
    localparam logic [X_W-1:0] C_TREE_X0  = X_W'(TREE_X0);
    localparam logic [X_W-1:0] C_TREE_X1  = X_W'(TREE_X1);
    localparam logic [X_W-1:0] C_GRAVE_X0 = X_W'(GRAVE_X);
    localparam logic [X_W-1:0] C_GRAVE_X1 = X_W'(GRAVE_X + GRAVE_W);
    localparam logic [Y_W-1:0] C_GRAVE_Y0 = Y_W'(GRAVE_Y);
    localparam logic [Y_W-1:0] C_GRAVE_Y1 = Y_W'(GRAVE_Y + GRAVE_H);

    logic w_plat_hit;

    // A reversed span (x_start > x_end) can never satisfy both bounds
    always_comb begin
        w_plat_hit = 1'b0;
        for (int i = 0; i < NUM_PLAT; i++) begin
            if (plat_tbl[i].en && (y == plat_tbl[i].y) &&
                (x >= plat_tbl[i].x_start) && (x <= plat_tbl[i].x_end)) begin
                w_plat_hit = 1'b1;
            end
        end
    end

    // Later rules override earlier ones
    always_comb begin
        colour = '0;
        if (w_plat_hit) begin
            colour = COLOUR_W'(PLATFORM_COLOUR);
        end
        if ((x <= C_X_MAX) && (y >= C_GRASS_Y0) && (y <= C_GRASS_Y1)) begin
            colour = COLOUR_W'(GRASS_COLOUR);
        end
        if ((x >= C_TREE_X0) && (x <= C_TREE_X1)) begin
            colour = COLOUR_W'(TREE_COLOUR);
        end
        if ((x >= C_GRAVE_X0) && (x <= C_GRAVE_X1) &&
            (y >= C_GRAVE_Y0) && (y <= C_GRAVE_Y1)) begin
            colour = COLOUR_W'(GRAVE_COLOUR);
        end
    end

endmodule
`default_nettype wire

// File: rtl/background_painter.sv
`default_nettype none
// ============================================================================
// Module   : background_painter
// Brief    : Sweeps the frame in raster order and streams background pixel
//            beats with valid/ready back-pressure; programmable platforms.
// Revision : 1.0
// ============================================================================
module background_painter
    import bg_pkg::*;
#(
    parameter int H_RES    = 320,
    parameter int V_RES    = 240,
    parameter int X_W      = 9,
    parameter int Y_W      = 9,
    parameter int NUM_PLAT = 8,
    parameter int IDX_W    = 3,
    parameter int COLOUR_W = 3
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    output logic                busy,
    output logic                done,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic                cfg_en,
    input  logic [X_W-1:0]      cfg_x_start,
    input  logic [X_W-1:0]      cfg_x_end,
    input  logic [Y_W-1:0]      cfg_y,
    output logic                cfg_err,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    input  logic                plot_ready
);

    localparam logic [X_W-1:0] C_X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] C_Y_LAST = Y_W'(V_RES - 1);

    state_t              r_state;
    logic [X_W-1:0]      r_sx;
    logic [Y_W-1:0]      r_sy;
    plat_t               r_tbl [NUM_PLAT];
    logic [COLOUR_W-1:0] w_colour;
    logic                w_advance;
    logic                w_cfg_ok;

    // Start has priority over a same-cycle table write
    assign w_cfg_ok  = cfg_we && (r_state == ST_IDLE) && !start &&
                       (int'(cfg_idx) < NUM_PLAT);
    assign w_advance = !plot || plot_ready;

    bg_colour_lookup #(
        .H_RES    (H_RES),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .NUM_PLAT (NUM_PLAT),
        .COLOUR_W (COLOUR_W)
    ) u_lookup (
        .x        (r_sx),
        .y        (r_sy),
        .plat_tbl (r_tbl),
        .colour   (w_colour)
    );

    always_ff @(posedge clock or negedge resetn) begin : p_fsm
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_sx    <= '0;
            r_sy    <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            plot    <= 1'b0;
            x       <= '0;
            y       <= '0;
            colour  <= '0;
            cfg_err <= 1'b0;
        end else begin
            done    <= 1'b0;
            cfg_err <= cfg_we && !w_cfg_ok;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_SWEEP;
                        r_sx    <= '0;
                        r_sy    <= '0;
                        busy    <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    if (w_advance) begin
                        x      <= r_sx;
                        y      <= r_sy;
                        colour <= w_colour;
                        plot   <= 1'b1;
                        // Counters park on the last pixel once it is handed off
                        if (r_sx == C_X_LAST) begin
                            if (r_sy == C_Y_LAST) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_sx <= '0;
                                r_sy <= r_sy + Y_W'(1);
                            end
                        end else begin
                            r_sx <= r_sx + X_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (plot && plot_ready) begin
                        plot    <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin : p_tbl
        if (!resetn) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (w_cfg_ok) begin
            for (int i = 0; i < NUM_PLAT; i++) begin
                if (IDX_W'(i) == cfg_idx) begin
                    r_tbl[i] <= '{en: cfg_en, x_start: cfg_x_start,
                                  x_end: cfg_x_end, y: cfg_y};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_background_painter.sv
`default_nettype none
// ============================================================================
// Module   : tb_background_painter
// Brief    : Self-checking bench: reduced-frame painter sweeps plus a
//            full-size colour lookup probed at fixed coordinates.
// Revision : 1.0
// ============================================================================
module tb_background_painter;
    import bg_pkg::*;

    localparam int TH     = 64;
    localparam int TV     = 24;
    localparam int NB     = TH * TV;
    localparam int TIDX_W = 4;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              start = 1'b0;
    logic              cfg_we = 1'b0;
    logic              cfg_en = 1'b0;
    logic              plot_ready = 1'b1;
    logic [TIDX_W-1:0] cfg_idx = '0;
    logic [8:0]        cfg_x_start = '0;
    logic [8:0]        cfg_x_end = '0;
    logic [8:0]        cfg_y = '0;
    logic              busy, done, cfg_err, plot;
    logic [8:0]        x, y;
    logic [2:0]        colour;

    logic [8:0]        lx = '0;
    logic [8:0]        ly = '0;
    logic [2:0]        lcol;
    plat_t             ltbl [8];
    plat_t             mtbl [8];

    int ncmp  = 0;
    int nfail = 0;

    int lpx [14] = '{0, 20, 100, 248, 60, 100, 59, 101, 240, 60, 30, 175, 200, 150};
    int lpy [14] = '{0, 100, 238, 172, 180, 180, 180, 180, 180, 181, 238, 190, 190, 190};

    always #5 clock = ~clock;

    background_painter #(
        .H_RES(TH), .V_RES(TV), .X_W(9), .Y_W(9),
        .NUM_PLAT(8), .IDX_W(TIDX_W), .COLOUR_W(3)
    ) dut (
        .clock(clock), .resetn(resetn), .start(start), .busy(busy), .done(done),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en),
        .cfg_x_start(cfg_x_start), .cfg_x_end(cfg_x_end), .cfg_y(cfg_y),
        .cfg_err(cfg_err), .x(x), .y(y), .colour(colour), .plot(plot),
        .plot_ready(plot_ready)
    );

    bg_colour_lookup #(
        .H_RES(320), .X_W(9), .Y_W(9), .NUM_PLAT(8), .COLOUR_W(3)
    ) u_lut (
        .x(lx), .y(ly), .plat_tbl(ltbl), .colour(lcol)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Highest-priority rule first; the first one that matches decides
    function automatic logic [2:0] ref_colour(input int px, input int py, input int hres,
                                              input plat_t tb [8]);
        if (px >= 245 && px <= 251 && py >= 169 && py <= 177) return 3'b111;
        if (px >= 15 && px <= 45) return 3'b111;
        if (px < hres && py >= 236 && py <= 250) return 3'b010;
        for (int i = 0; i < 8; i++) begin
            if (tb[i].en && py == int'(tb[i].y) &&
                px >= int'(tb[i].x_start) && px <= int'(tb[i].x_end)) return 3'b111;
        end
        return 3'b000;
    endfunction

    task automatic cfg_write(input int idx, input bit en, input int xs, input int xe, input int yy);
        bit exp_err;
        exp_err = (idx >= 8);
        @(negedge clock);
        cfg_we = 1'b1; cfg_idx = TIDX_W'(idx); cfg_en = en;
        cfg_x_start = 9'(xs); cfg_x_end = 9'(xe); cfg_y = 9'(yy);
        @(negedge clock);
        cfg_we = 1'b0;
        chk($sformatf("cfg_err_idx%0d", idx), cfg_err, exp_err);
        if (!exp_err) mtbl[idx] = '{en, 9'(xs), 9'(xe), 9'(yy)};
    endtask

    // One frame: beat order/colour, stall hold, done timing; optional
    // same-cycle start+write, mid-sweep poke, and reset abort at a beat count.
    task automatic sweep(input bit rnd, input bit we_with_start, input bit poke,
                         input int abort_beat);
        int n, beats, ex, ey, last_acc;
        bit stalled, fin, rdy;
        logic [8:0] sx, sy;
        logic [2:0] sc;
        n = 0; beats = 0; ex = 0; ey = 0; last_acc = 0;
        stalled = 1'b0; fin = 1'b0; sx = '0; sy = '0; sc = '0;
        @(negedge clock);
        start = 1'b1;
        plot_ready = 1'b1;
        if (we_with_start) begin
            cfg_we = 1'b1; cfg_idx = 4'd4; cfg_en = 1'b1;
            cfg_x_start = 9'd0; cfg_x_end = 9'd63; cfg_y = 9'd4;
        end
        while (!fin && n < 4 * NB + 50) begin
            @(negedge clock);
            n++;
            start = 1'b0;
            cfg_we = 1'b0;
            if (n == 1) begin
                chk("busy_plot_n1", {busy, plot}, 2'b10);
                if (we_with_start) chk("cfg_err_start_we", cfg_err, 1'b1);
            end
            if (!rnd && n == 2) chk("first_beat_n2", {plot, x, y}, {1'b1, 9'd0, 9'd0});
            if (poke && n == 5) begin
                start = 1'b1; cfg_we = 1'b1; cfg_idx = 4'd3; cfg_en = 1'b1;
                cfg_x_start = 9'd0; cfg_x_end = 9'd63; cfg_y = 9'd3;
            end
            if (poke && n == 6) chk("cfg_err_busy", cfg_err, 1'b1);
            if (stalled) chk("stall_hold", {plot, x, y, colour}, {1'b1, sx, sy, sc});
            if (done) begin
                chk("busy_at_done", busy, 1'b0);
                chk("beat_count", beats, NB);
                chk("done_cycle", n, rnd ? last_acc + 1 : NB + 2);
                fin = 1'b1;
            end else begin
                rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
                plot_ready = rdy;
                if (plot && rdy) begin
                    chk($sformatf("beat%0d", beats), {x, y, colour},
                        {9'(ex), 9'(ey), ref_colour(ex, ey, TH, mtbl)});
                    beats++;
                    last_acc = n;
                    if (ex == TH - 1) begin ex = 0; ey++; end else ex++;
                    if (beats == abort_beat) begin
                        #2 resetn = 1'b0;
                        #1 chk("abort_async", {plot, busy, done}, 3'b000);
                        fin = 1'b1;
                    end
                end
                stalled = plot && !rdy;
                sx = x; sy = y; sc = colour;
            end
        end
        if (!fin) chk("sweep_timeout", 1'b0, 1'b1);
        plot_ready = 1'b1;
    endtask

    initial begin
        bit seen_done;
        for (int i = 0; i < 8; i++) begin
            mtbl[i] = '0;
            ltbl[i] = '0;
        end

        // Lookup at full-frame coordinates
        ltbl[0] = '{1'b1, 9'd60, 9'd100, 9'd180};
        ltbl[1] = '{1'b1, 9'd220, 9'd260, 9'd180};
        ltbl[2] = '{1'b1, 9'd200, 9'd150, 9'd190};
        for (int i = 0; i < 14; i++) begin
            lx = 9'(lpx[i]);
            ly = 9'(lpy[i]);
            #1;
            chk($sformatf("lut(%0d,%0d)", lpx[i], lpy[i]), lcol,
                ref_colour(lpx[i], lpy[i], 320, ltbl));
        end

        #3;
        chk("reset_state", {busy, done, plot, cfg_err, x, y, colour}, '0);
        @(negedge clock);
        resetn = 1'b1;

        // Empty table, plot_ready high
        sweep(1'b0, 1'b0, 1'b0, -1);

        // Platforms, a reversed entry, then a rejected out-of-range index
        cfg_write(0, 1'b1, 48, 58, 10);
        cfg_write(1, 1'b1, 50, 63, 12);
        cfg_write(2, 1'b1, 60, 50, 5);
        cfg_write(9, 1'b1, 0, 63, 7);

        // Random back-pressure with a start+write poke while busy
        sweep(1'b1, 1'b0, 1'b1, -1);

        // Start beats a same-cycle write; reset lands mid-frame
        sweep(1'b0, 1'b1, 1'b0, 1000);
        for (int i = 0; i < 8; i++) mtbl[i] = '0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        seen_done = 1'b0;
        repeat (5) begin
            @(negedge clock);
            seen_done = seen_done | done;
        end
        chk("no_done_after_abort", seen_done, 1'b0);

        // Fresh frame after reset: table must be empty again
        sweep(1'b0, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/background_painter.md
Name: background_painter

Overview:
- Parametrised successor to the fixed background colour lookup.
- On a `start` pulse it sweeps every pixel of the frame, one per cycle, and emits (x, y, colour, plot) beats to the VGA framebuffer writer.
- Colour comes from a run-time programmable platform table plus the fixed grass band, tree column and grave box.
- Sits between the game control FSM (start/done) and the VGA adapter write port. Back-pressure is taken via `plot_ready`.

Parameters:
- H_RES, 320, horizontal pixel count; x sweeps 0..H_RES-1.
- V_RES, 240, vertical pixel count; y sweeps 0..V_RES-1.
- X_W, 9, x coordinate width.
- Y_W, 9, y coordinate width.
- NUM_PLAT, 8, platform table entries.
- IDX_W, 3, platform index width; must satisfy 2^IDX_W >= NUM_PLAT.
- COLOUR_W, 3, colour width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to paint a frame.
- busy  out  1  high from the first cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last beat is accepted.
- cfg_we  in  1  platform table write strobe.
- cfg_idx  in  IDX_W  table entry to write.
- cfg_en  in  1  entry enable.
- cfg_x_start  in  X_W  platform left x, inclusive.
- cfg_x_end  in  X_W  platform right x, inclusive.
- cfg_y  in  Y_W  platform row.
- cfg_err  out  1  one-cycle pulse: write rejected.
- x  out  X_W  pixel x.
- y  out  Y_W  pixel y.
- colour  out  COLOUR_W  pixel colour.
- plot  out  1  beat valid.
- plot_ready  in  1  sink accepts the beat when plot && plot_ready.

Behaviour:
- Reset values:
  - busy=0, done=0, plot=0, x=0, y=0, colour=0, cfg_err=0.
  - All table entries disabled, coordinate fields 0.
  - The FSM goes to IDLE.
  - Reset asserted mid-sweep aborts immediately; no done pulse is produced.
- FSM states: IDLE, SWEEP, DRAIN.
  - IDLE: start=1 -> SWEEP. The scan counters (sx, sy) load 0,0 and busy rises next cycle.
  - SWEEP: the counters advance when output stage 1 is empty or being accepted.
    - Order: x fastest. At sx=H_RES-1, sx wraps to 0 and sy increments.
    - At (H_RES-1, V_RES-1) the counters stop and the FSM goes to DRAIN.
  - DRAIN: when the final beat is accepted -> IDLE, with done=1 for one cycle in that transition cycle's successor and busy=0 in the same cycle.
- Pipeline:
  - Two stages: counter stage, then registered output stage (x, y, colour, plot).
  - First beat (0,0) appears with plot=1 two cycles after start is sampled.
  - With plot_ready held high, throughput is 1 beat/cycle: H_RES*V_RES beats, done H_RES*V_RES+2 cycles after start.
  - plot_ready=0: x, y, colour and plot hold stable and the counters freeze. No beat is lost or duplicated.
- Colour priority (later wins), default 0:
  - Enabled platform i where y==cfg_y[i] and x_start[i]<=x<=x_end[i] -> PLATFORM_COLOUR. Any number of entries may overlap.
  - x in [0,H_RES-1] and y in [GRASS_Y0,GRASS_Y1] -> GRASS_COLOUR.
  - x in [TREE_X0,TREE_X1] -> TREE_COLOUR, over the full column height.
  - x in [GRAVE_X,GRAVE_X+GRAVE_W] and y in [GRAVE_Y,GRAVE_Y+GRAVE_H] -> GRAVE_COLOUR.
- Comparisons are unsigned at full X_W/Y_W. An entry with x_start>x_end matches nothing.
- Config writes:
  - Accepted only in IDLE, effective for the next sweep.
  - cfg_we while busy, or in the cycle start is accepted, is dropped and cfg_err pulses.
  - cfg_idx>=NUM_PLAT is dropped and cfg_err pulses.
  - start while busy is ignored.
  - start and cfg_we in the same IDLE cycle: start wins, the write is dropped and cfg_err pulses.

Decomposition:
- Package bg_pkg holds:
  - PLATFORM_COLOUR=3'b111, GRASS_COLOUR=3'b010, TREE_COLOUR=3'b111, GRAVE_COLOUR=3'b111.
  - GRASS_Y0=236, GRASS_Y1=250.
  - TREE_X0=15, TREE_X1=45.
  - GRAVE_X=245, GRAVE_W=6, GRAVE_Y=169, GRAVE_H=8.
  - The FSM state enum and the platform entry struct (en, x_start, x_end, y).
- Sub-module bg_colour_lookup: purely combinational (x, y, table) -> colour. It is reused by the sprite collision block.

Test Plan:
- Table empty, plot_ready=1, start:
  - first beat (0,0) colour 0 two cycles after start;
  - (20,100) colour 3'b111 (tree);
  - (100,238) 3'b010;
  - (248,172) 3'b111;
  - exactly 76800 beats;
  - done pulse at cycle 76802.
- Write idx0 {en=1, 60..100, y=180}, idx1 {en=1, 220..260, y=180}, sweep:
  - (60,180)=7, (100,180)=7, (59,180)=0, (101,180)=0, (240,180)=7, (60,181)=0.
- Toggle plot_ready pseudo-randomly during a sweep:
  - beat sequence strictly raster order, no gaps or repeats;
  - outputs stable while stalled;
  - 76800 beats total.
- cfg_we during busy, cfg_idx=9 (NUM_PLAT=8), and start+cfg_we in the same cycle:
  - each gives a cfg_err pulse and the table is unchanged;
  - start while busy has no effect on count.
- Assert resetn low at beat 1000, release, then start:
  - plot/busy/done drop to 0 asynchronously;
  - the table is cleared;
  - the new sweep begins at (0,0) with no done pulse from the aborted frame.
- Entry with x_start=200 > x_end=150, enabled: no platform pixels on its row.
